// File: rtl/demux_buf_if.sv
// demux_buf_if: producer/consumer bus for demux_buf; cnt_a/cnt_b exist only with DEMUX_CNT_EN.
interface demux_buf_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_sel;
    logic [8:0] a;
    logic [8:0] b;
    logic       pop_a;
    logic       pop_b;
`ifdef DEMUX_CNT_EN
    logic [7:0] cnt_a;
    logic [7:0] cnt_b;
`endif
    modport master (
        output in_valid, in_data, in_sel, pop_a, pop_b,
`ifdef DEMUX_CNT_EN
        input  cnt_a, cnt_b,
`endif
        input  in_ready, a, b
    );
    modport slave (
        input  in_valid, in_data, in_sel, pop_a, pop_b,
`ifdef DEMUX_CNT_EN
        output cnt_a, cnt_b,
`endif
        output in_ready, a, b
    );
endinterface

// File: rtl/demux_buf.sv
// demux_buf: 1-to-2 demux into two independent register FIFOs with registered head outputs.
// Optional DEMUX_CNT_EN adds saturating per-channel accepted-word counters.
module demux_buf #(
    parameter int DEPTH = 4
) (
    input logic       clk,
    input logic       rst_n,
    demux_buf_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [7:0]  mem [2][DEPTH];
    logic [AW:0] rp [2];
    logic [AW:0] wp [2];
    logic [AW:0] occ [2];
    logic [1:0]  push;
    logic [1:0]  pop;
    logic        rdy;
    // Heads come straight from registers, so pop_a/pop_b never reach an output combinationally.
    always_comb begin
        rdy = occ[bus.in_sel] != FULL;
        push = {2{bus.in_valid & rdy}} & {bus.in_sel, ~bus.in_sel};
        pop = {bus.pop_b & (occ[1] != '0), bus.pop_a & (occ[0] != '0)};
        bus.a = (occ[0] != '0) ? {1'b1, mem[0][rp[0][AW-1:0]]} : 9'h000;
        bus.b = (occ[1] != '0) ? {1'b1, mem[1][rp[1][AW-1:0]]} : 9'h000;
    end
    assign bus.in_ready = rdy;
    always_ff @(posedge clk)
        for (int c = 0; c < 2; c++)
            if (push[c]) mem[c][wp[c][AW-1:0]] <= bus.in_data;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) begin
                rp[c]  <= '0;
                wp[c]  <= '0;
                occ[c] <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (push[c]) wp[c] <= wp[c] + 1'b1;
                if (pop[c]) rp[c] <= rp[c] + 1'b1;
                occ[c] <= occ[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
            end
        end
`ifdef DEMUX_CNT_EN
    logic [7:0] cnt [2];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int c = 0; c < 2; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) cnt[c] <= cnt[c] + 8'(push[c] && cnt[c] != 8'hFF);
        end
    assign bus.cnt_a = cnt[0];
    assign bus.cnt_b = cnt[1];
`endif
endmodule

// File: tb/tb_demux_buf.sv
// tb_demux_buf: directed stimulus pushes expected heads/ready into a queue; a negedge monitor pops and compares.
module tb_demux_buf;
    logic clk = 0;
    logic rst_n = 0;
    int   total = 0;
    int   passed = 0;
    demux_buf_if bus ();
    demux_buf #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        string      name;
        logic [8:0] a;
        logic [8:0] b;
        logic       rdy;
        logic       cc;
        logic [7:0] ca;
        logic [7:0] cb;
    } exp_t;
    exp_t q[$];
    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] req);
        total++;
        if (act !== req) $display("FAIL %s: got %h expected %h", name, act, req);
        else passed++;
    endtask
    always @(negedge clk)
        if (q.size() != 0) begin
            exp_t r;
            r = q.pop_front();
            chk({r.name, ".a"}, bus.a, r.a);
            chk({r.name, ".b"}, bus.b, r.b);
            chk({r.name, ".rdy"}, {8'h0, bus.in_ready}, {8'h0, r.rdy});
`ifdef DEMUX_CNT_EN
            if (r.cc) begin
                chk({r.name, ".cnt_a"}, {1'b0, bus.cnt_a}, {1'b0, r.ca});
                chk({r.name, ".cnt_b"}, {1'b0, bus.cnt_b}, {1'b0, r.cb});
            end
`endif
        end
    // Expected values describe the state seen at the following negedge with these inputs applied.
    task automatic step(input logic r, input logic v, input logic sel, input logic [7:0] d,
                        input logic pa, input logic pb, input string name,
                        input logic [8:0] ea, input logic [8:0] eb, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        bus.in_valid = v;
        bus.in_sel = sel;
        bus.in_data = d;
        bus.pop_a = pa;
        bus.pop_b = pb;
        e = '{name, ea, eb, er, 1'b0, 8'h00, 8'h00};
        q.push_back(e);
    endtask
    initial begin
        bus.in_valid = 0;
        bus.in_sel = 0;
        bus.in_data = 0;
        bus.pop_a = 0;
        bus.pop_b = 0;
        step(0, 0, 0, 8'h00, 0, 0, "rst_sel0", 9'h000, 9'h000, 1);
        step(0, 1, 1, 8'hFF, 0, 0, "rst_sel1", 9'h000, 9'h000, 1);
        step(1, 1, 0, 8'h11, 0, 0, "push11",   9'h000, 9'h000, 1);
        step(1, 1, 1, 8'h22, 0, 0, "push22",   9'h111, 9'h000, 1);
        step(1, 0, 0, 8'h00, 0, 0, "both",     9'h111, 9'h122, 1);
        step(1, 0, 0, 8'h00, 1, 1, "pop_ab",   9'h111, 9'h122, 1);
        step(1, 0, 0, 8'h00, 0, 0, "drained",  9'h000, 9'h000, 1);
        step(1, 1, 0, 8'hA0, 0, 0, "fillA0",   9'h000, 9'h000, 1);
        step(1, 1, 0, 8'hA1, 0, 0, "fillA1",   9'h1A0, 9'h000, 1);
        step(1, 1, 0, 8'hA2, 0, 0, "fillA2",   9'h1A0, 9'h000, 1);
        step(1, 1, 0, 8'hA3, 0, 0, "fillA3",   9'h1A0, 9'h000, 1);
        step(1, 1, 0, 8'hA4, 0, 0, "full_sel0", 9'h1A0, 9'h000, 0);
        step(1, 0, 1, 8'h00, 0, 0, "full_sel1", 9'h1A0, 9'h000, 1);
        step(1, 1, 0, 8'hEE, 1, 0, "full_pop", 9'h1A0, 9'h000, 0);
        step(1, 0, 0, 8'h00, 1, 0, "popA1",    9'h1A1, 9'h000, 1);
        step(1, 0, 0, 8'h00, 1, 0, "popA2",    9'h1A2, 9'h000, 1);
        step(1, 0, 0, 8'h00, 1, 0, "popA3",    9'h1A3, 9'h000, 1);
        step(1, 0, 0, 8'h00, 0, 0, "emptyA",   9'h000, 9'h000, 1);
        step(1, 1, 0, 8'h31, 0, 0, "push31",   9'h000, 9'h000, 1);
        step(1, 1, 0, 8'h32, 0, 0, "push32",   9'h131, 9'h000, 1);
        step(1, 1, 0, 8'h55, 1, 0, "pushpop",  9'h131, 9'h000, 1);
        step(1, 0, 0, 8'h00, 1, 0, "after_pp", 9'h132, 9'h000, 1);
        step(1, 0, 0, 8'h00, 1, 0, "head55",   9'h155, 9'h000, 1);
        step(1, 0, 0, 8'h00, 0, 0, "occ2_end", 9'h000, 9'h000, 1);
        step(1, 0, 1, 8'h00, 0, 1, "udf1",     9'h000, 9'h000, 1);
        step(1, 0, 1, 8'h00, 0, 1, "udf2",     9'h000, 9'h000, 1);
        step(1, 0, 1, 8'h00, 0, 1, "udf3",     9'h000, 9'h000, 1);
        step(1, 1, 1, 8'h7E, 0, 0, "push7E",   9'h000, 9'h000, 1);
        step(1, 1, 0, 8'h66, 0, 1, "xpushpop", 9'h000, 9'h17E, 1);
        step(1, 0, 0, 8'h00, 1, 0, "x_result", 9'h166, 9'h000, 1);
        step(1, 0, 0, 8'h00, 0, 0, "x_empty",  9'h000, 9'h000, 1);
        step(1, 1, 0, 8'h01, 0, 0, "push01",   9'h000, 9'h000, 1);
        step(1, 1, 0, 8'h02, 0, 0, "push02",   9'h101, 9'h000, 1);
        step(1, 0, 0, 8'h00, 0, 0, "hold2",    9'h101, 9'h000, 1);
        step(0, 0, 0, 8'h00, 0, 0, "async_rst", 9'h000, 9'h000, 1);
        step(0, 0, 1, 8'h00, 0, 0, "rst_hold", 9'h000, 9'h000, 1);
        step(1, 0, 0, 8'h00, 0, 0, "post_rst", 9'h000, 9'h000, 1);
`ifdef DEMUX_CNT_EN
        begin
            exp_t e;
            @(posedge clk);
            #1;
            e = '{"cnt_zero", 9'h000, 9'h000, 1'b1, 1'b1, 8'h00, 8'h00};
            q.push_back(e);
            for (int i = 0; i < 300; i++) begin
                @(posedge clk);
                #1;
                bus.in_valid = 1;
                bus.in_sel = 1;
                bus.in_data = 8'(i);
                bus.pop_b = 1;
            end
            @(posedge clk);
            #1;
            bus.in_valid = 0;
            bus.pop_b = 1;
            e = '{"cnt_sat", 9'h000, 9'h12B, 1'b1, 1'b1, 8'h00, 8'hFF};
            q.push_back(e);
            step(1, 0, 1, 8'h00, 0, 0, "cnt_drain", 9'h000, 9'h000, 1);
        end
`endif
        begin
            int budget = 10;
            while (q.size() != 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            total++;
            if (q.size() != 0) $display("FAIL drain: %0d expectations left, expected 0", q.size());
            else passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
